regex_multi_ctrl: RTL and testbench

Register-driven control front-end for N_CH regex coprocessor channels that share one dual-width instruction/data BRAM. It is the multi-channel successor of the single-coprocessor AXI control block. It decodes host commands from the AXI register file, tracks per-channel run state, and keeps saturating per-channel cycle counters with an optional timeout. It also round-robin arbitrates the BRAM read port among running channels. BRAM and coprocessor instances sit outside the block and connect to its ports.

---
 rtl/regex_multi_ctrl_if.sv | 64 ++++++
 rtl/regex_multi_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_regex_multi_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regex_multi_ctrl_if.sv
// Bundle of the host register file, shared BRAM ports and per-channel
// coprocessor handshakes for regex_multi_ctrl.
// The master modport is the controller's view; the slave modport is the
// view of everything around it (host, BRAM, coprocessors).
interface regex_multi_ctrl_if #(
    parameter int REG_WIDTH        = 32,
    parameter int N_CH             = 2,
    parameter int MEM_R_WIDTH      = 128,
    parameter int MEM_R_ADDR_WIDTH = 8,
    parameter int MEM_W_WIDTH      = 32,
    parameter int MEM_W_ADDR_WIDTH = 10
);
    logic [REG_WIDTH-1:0]             cmd_register;
    logic [REG_WIDTH-1:0]             address_register;
    logic [REG_WIDTH-1:0]             data_in_register;
    logic [REG_WIDTH-1:0]             channel_register;
    logic [REG_WIDTH-1:0]             timeout_register;
    logic [REG_WIDTH-1:0]             status_register;
    logic [REG_WIDTH-1:0]             data_o_register;

    logic [MEM_R_ADDR_WIDTH-1:0]      mem_r_addr;
    logic                             mem_r_valid;
    logic [MEM_R_WIDTH-1:0]           mem_r_data;
    logic [MEM_W_ADDR_WIDTH-1:0]      mem_w_addr;
    logic [MEM_W_WIDTH-1:0]           mem_w_data;
    logic                             mem_w_valid;

    logic [N_CH-1:0]                  cop_rst;
    logic [N_CH-1:0]                  cop_start_valid;
    logic [N_CH-1:0]                  cop_start_ready;
    logic [N_CH-1:0]                  cop_done;
    logic [N_CH-1:0]                  cop_accept;
    logic [N_CH-1:0]                  cop_error;
    logic [N_CH*MEM_R_ADDR_WIDTH-1:0] cop_mem_addr;
    logic [N_CH-1:0]                  cop_mem_valid;
    logic [N_CH-1:0]                  cop_mem_ready;
    logic [N_CH-1:0]                  cop_mem_rdata_valid;

    modport master (
        input  cmd_register, address_register, data_in_register,
               channel_register, timeout_register,
        output status_register, data_o_register,
        output mem_r_addr, mem_r_valid,
        input  mem_r_data,
        output mem_w_addr, mem_w_data, mem_w_valid,
        output cop_rst, cop_start_valid,
        input  cop_start_ready, cop_done, cop_accept, cop_error,
        input  cop_mem_addr, cop_mem_valid,
        output cop_mem_ready, cop_mem_rdata_valid
    );

    modport slave (
        output cmd_register, address_register, data_in_register,
               channel_register, timeout_register,
        input  status_register, data_o_register,
        input  mem_r_addr, mem_r_valid,
        output mem_r_data,
        input  mem_w_addr, mem_w_data, mem_w_valid,
        input  cop_rst, cop_start_valid,
        output cop_start_ready, cop_done, cop_accept, cop_error,
        output cop_mem_addr, cop_mem_valid,
        input  cop_mem_ready, cop_mem_rdata_valid
    );
endinterface

// File: rtl/regex_multi_ctrl.sv
// Multi-channel regex coprocessor control front-end.
// Decodes level-sensitive host commands, tracks per-channel run state and
// saturating cycle counters with optional timeout, and round-robin shares
// the BRAM read port among channels that are running or starting.
// Command encodings follow the AXI control command set, with ABORT appended:
//   1 RESET, 2 WRITE, 3 READ, 4 START, 5 RESTART, 6 READ_ELAPSED_CLOCK, 7 ABORT
module regex_multi_ctrl #(
    parameter int REG_WIDTH        = 32,
    parameter int N_CH             = 2,
    parameter int MEM_R_WIDTH      = 128,
    parameter int MEM_R_ADDR_WIDTH = 8,
    parameter int MEM_W_WIDTH      = 32,
    parameter int MEM_W_ADDR_WIDTH = 10
) (
    input logic                clk,
    input logic                rst,
    regex_multi_ctrl_if.master bus
);
    localparam int N_WORDS = MEM_R_WIDTH / REG_WIDTH;
    localparam int OFF     = $clog2(N_WORDS);
    localparam int SEL_W   = (OFF > 0) ? OFF : 1;
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW      = MEM_R_ADDR_WIDTH;

    localparam logic [REG_WIDTH-1:0] CMD_RESET        = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] CMD_WRITE        = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] CMD_READ         = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] CMD_START        = REG_WIDTH'(4);
    localparam logic [REG_WIDTH-1:0] CMD_RESTART      = REG_WIDTH'(5);
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED = REG_WIDTH'(6);
    localparam logic [REG_WIDTH-1:0] CMD_ABORT        = REG_WIDTH'(7);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RUNNING  = 3'd1;
    localparam logic [2:0] ST_ACCEPTED = 3'd2;
    localparam logic [2:0] ST_REJECTED = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;
    localparam logic [2:0] ST_TIMEOUT  = 3'd5;

    logic [N_CH-1:0][2:0]           state;
    logic [N_CH-1:0][2:0]           next_state;
    logic [N_CH-1:0][REG_WIDTH-1:0] elapsed;
    logic [CH_W-1:0]                rr_ptr;
    logic [CH_W-1:0]                rr_next;
    logic [N_CH-1:0]                rdata_valid_q;

    logic                           soft_rst;
    logic                           busy;
    logic                           ch_valid;
    logic [CH_W-1:0]                ch_idx;
    logic                           cmd_write, cmd_read, cmd_start;
    logic                           cmd_restart, cmd_elapsed, cmd_abort;
    logic                           host_write, host_read;
    logic [SEL_W-1:0]               word_sel;
    logic [N_CH-1:0]                start_valid;
    logic [N_CH-1:0]                rst_pulse;
    logic [N_CH-1:0]                eligible;
    logic [N_CH-1:0]                grant;
    logic                           grant_any;
    int                             grant_idx;
    int                             scan_idx;
    logic [REG_WIDTH-1:0]           read_word;
    logic                           unused_bits;

    assign unused_bits = ^{bus.address_register, bus.data_in_register, bus.channel_register};

    // Command decode; a host RESET command behaves exactly like the rst pin
    always_comb begin
        soft_rst    = rst || (bus.cmd_register == CMD_RESET);
        cmd_write   = !soft_rst && (bus.cmd_register == CMD_WRITE);
        cmd_read    = !soft_rst && (bus.cmd_register == CMD_READ);
        cmd_start   = !soft_rst && (bus.cmd_register == CMD_START);
        cmd_restart = !soft_rst && (bus.cmd_register == CMD_RESTART);
        cmd_elapsed = !soft_rst && (bus.cmd_register == CMD_READ_ELAPSED);
        cmd_abort   = !soft_rst && (bus.cmd_register == CMD_ABORT);
        ch_valid    = bus.channel_register < REG_WIDTH'(N_CH);
        ch_idx      = bus.channel_register[CH_W-1:0];
        busy        = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (state[i] == ST_RUNNING) busy = 1'b1;
        end
        host_write  = cmd_write && !busy;
        host_read   = cmd_read && !busy;
        word_sel    = (OFF > 0) ? bus.address_register[SEL_W-1:0] : '0;
    end

    // Per-channel next state, start handshake and coprocessor reset pulses
    always_comb begin
        next_state  = state;
        start_valid = '0;
        rst_pulse   = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (state[i])
                ST_IDLE: begin
                    if (cmd_start && ch_valid && (int'(ch_idx) == i)) begin
                        start_valid[i] = 1'b1;
                        if (bus.cop_start_ready[i]) next_state[i] = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (bus.cop_error[i]) begin
                        next_state[i] = ST_ERROR;
                    end else if (bus.cop_done[i]) begin
                        next_state[i] = bus.cop_accept[i] ? ST_ACCEPTED : ST_REJECTED;
                    end else if (cmd_abort && ch_valid && (int'(ch_idx) == i)) begin
                        next_state[i] = ST_IDLE;
                        rst_pulse[i]  = 1'b1;
                    end else if ((bus.timeout_register != '0) &&
                                 (elapsed[i] == bus.timeout_register - REG_WIDTH'(1))) begin
                        next_state[i] = ST_TIMEOUT;
                        rst_pulse[i]  = 1'b1;
                    end
                end
                ST_ACCEPTED, ST_REJECTED, ST_ERROR, ST_TIMEOUT: begin
                    if (cmd_restart && ch_valid && (int'(ch_idx) == i)) next_state[i] = ST_IDLE;
                end
                default: next_state[i] = ST_IDLE;
            endcase
        end
    end

    // Round-robin grant of the BRAM read port, scanning from rr_ptr
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = 0;
        scan_idx  = 0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = !soft_rst && bus.cop_mem_valid[i] &&
                          ((state[i] == ST_RUNNING) || start_valid[i]);
        end
        for (int k = 0; k < N_CH; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_CH;
            if (!grant_any && eligible[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_any       = 1'b1;
                grant_idx       = scan_idx;
            end
        end
        rr_next = CH_W'((grant_idx + 1) % N_CH);
    end

    // Select the host-addressed word out of the wide BRAM read row
    always_comb begin
        read_word = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (int'(word_sel) == w) read_word = bus.mem_r_data[w*REG_WIDTH +: REG_WIDTH];
        end
    end

    // Drive BRAM ports, coprocessor controls, status and read-back data
    always_comb begin
        bus.mem_w_valid     = host_write;
        bus.mem_w_addr      = host_write ? bus.address_register[0 +: MEM_W_ADDR_WIDTH] : '0;
        bus.mem_w_data      = host_write ? bus.data_in_register[0 +: MEM_W_WIDTH] : '0;
        bus.mem_r_valid     = grant_any || host_read;
        bus.mem_r_addr      = '0;
        if (grant_any) begin
            bus.mem_r_addr = bus.cop_mem_addr[grant_idx*AW +: AW];
        end else if (host_read) begin
            bus.mem_r_addr = bus.address_register[OFF +: AW];
        end
        bus.cop_mem_ready       = grant;
        bus.cop_start_valid     = start_valid;
        bus.cop_rst             = soft_rst ? '1 : rst_pulse;
        bus.cop_mem_rdata_valid = soft_rst ? '0 : rdata_valid_q;
        bus.data_o_register     = '0;
        if (host_read) begin
            bus.data_o_register = read_word;
        end else if (cmd_elapsed && ch_valid) begin
            bus.data_o_register = elapsed[ch_idx];
        end
        bus.status_register = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.status_register[4*i +: 4] = {1'b0, state[i]};
        end
        bus.status_register[REG_WIDTH-1] = busy;
    end

    // Registered channel state, saturating counters, arbiter pointer and read-data strobe
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state         <= '0;
            elapsed       <= '0;
            rr_ptr        <= '0;
            rdata_valid_q <= '0;
        end else begin
            state         <= next_state;
            rdata_valid_q <= grant;
            if (grant_any) rr_ptr <= rr_next;
            for (int i = 0; i < N_CH; i++) begin
                if (start_valid[i]) begin
                    elapsed[i] <= '0;
                end else if ((state[i] == ST_RUNNING) && (elapsed[i] != '1)) begin
                    elapsed[i] <= elapsed[i] + REG_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_regex_multi_ctrl.sv
// Scoreboard bench for regex_multi_ctrl: stimulus pushes expected values,
// a negedge monitor pops and compares them when the DUT presents outputs.
module tb_regex_multi_ctrl;
    localparam logic [31:0] CMD_NOP          = 32'd0;
    localparam logic [31:0] CMD_RESET        = 32'd1;
    localparam logic [31:0] CMD_WRITE        = 32'd2;
    localparam logic [31:0] CMD_READ         = 32'd3;
    localparam logic [31:0] CMD_START        = 32'd4;
    localparam logic [31:0] CMD_RESTART      = 32'd5;
    localparam logic [31:0] CMD_READ_ELAPSED = 32'd6;
    localparam logic [31:0] CMD_ABORT        = 32'd7;

    localparam int K_STATUS = 0;
    localparam int K_DATAO  = 1;
    localparam int K_COPRST = 2;
    localparam int K_WVALID = 3;
    localparam int K_RVALID = 4;
    localparam int K_RADDR  = 5;
    localparam int K_STARTV = 6;
    localparam int K_READY  = 7;
    localparam int K_RDV    = 8;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          tests_run;
    int          tests_failed;
    exp_t        pend[$];
    logic [41:0] wr_q[$];
    logic [1:0]  rd_q[$];
    logic [31:0] bram [0:1023];
    logic [1:0]  gnt;

    regex_multi_ctrl_if #(
        .REG_WIDTH(32), .N_CH(2), .MEM_R_WIDTH(128), .MEM_R_ADDR_WIDTH(8),
        .MEM_W_WIDTH(32), .MEM_W_ADDR_WIDTH(10)
    ) bus ();

    regex_multi_ctrl #(
        .REG_WIDTH(32), .N_CH(2), .MEM_R_WIDTH(128), .MEM_R_ADDR_WIDTH(8),
        .MEM_W_WIDTH(32), .MEM_W_ADDR_WIDTH(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time scoreboard entries
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: word-wide writes, four-word row reads with one cycle latency
    always @(posedge clk) begin
        if (bus.mem_w_valid) bram[bus.mem_w_addr] <= bus.mem_w_data;
        if (bus.mem_r_valid) begin
            bus.mem_r_data <= {bram[{bus.mem_r_addr, 2'd3}], bram[{bus.mem_r_addr, 2'd2}],
                               bram[{bus.mem_r_addr, 2'd1}], bram[{bus.mem_r_addr, 2'd0}]};
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_STATUS: return bus.status_register;
            K_DATAO:  return bus.data_o_register;
            K_COPRST: return {30'd0, bus.cop_rst};
            K_WVALID: return {31'd0, bus.mem_w_valid};
            K_RVALID: return {31'd0, bus.mem_r_valid};
            K_RADDR:  return {24'd0, bus.mem_r_addr};
            K_STARTV: return {30'd0, bus.cop_start_valid};
            K_READY:  return {30'd0, bus.cop_mem_ready};
            K_RDV:    return {30'd0, bus.cop_mem_rdata_valid};
            default:  return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: timed snapshot checks plus write and read-data event queues
    always @(negedge clk) begin
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].cyc == cyc) begin
                checkOutput(pend[i].name, {32'd0, observe(pend[i].kind)}, {32'd0, pend[i].val});
                pend.delete(i);
            end
        end
        if (!rst && bus.mem_w_valid) begin
            if (wr_q.size() == 0) begin
                checkOutput("unexpected_write", {22'd0, bus.mem_w_addr, bus.mem_w_data}, 64'd0);
            end else begin
                checkOutput("write_event", {22'd0, bus.mem_w_addr, bus.mem_w_data}, {22'd0, wr_q.pop_front()});
            end
        end
        if (bus.cop_mem_rdata_valid != 2'b00) begin
            if (rd_q.size() == 0) begin
                checkOutput("unexpected_rdata_valid", {62'd0, bus.cop_mem_rdata_valid}, 64'd0);
            end else begin
                checkOutput("rdata_valid_event", {62'd0, bus.cop_mem_rdata_valid}, {62'd0, rd_q.pop_front()});
            end
        end
    end

    task automatic expectAt(input int delay, input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + delay;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        pend.push_back(e);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic setCmd(input logic [31:0] cmd, input logic [31:0] ch);
        bus.cmd_register     = cmd;
        bus.channel_register = ch;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence
    initial begin
        cyc = 0;
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 1024; i++) bram[i] = 32'd0;
        bus.mem_r_data       = '0;
        rst                  = 1'b1;
        bus.cmd_register     = CMD_NOP;
        bus.address_register = '0;
        bus.data_in_register = '0;
        bus.channel_register = '0;
        bus.timeout_register = '0;
        bus.cop_start_ready  = '0;
        bus.cop_done         = '0;
        bus.cop_accept       = '0;
        bus.cop_error        = '0;
        bus.cop_mem_addr     = '0;
        bus.cop_mem_valid    = '0;
        applyStimulus(2);

        // Reset behaviour
        expectAt(0, K_COPRST, 32'h3, "reset_cop_rst");
        expectAt(0, K_STATUS, 32'h0, "reset_status");
        expectAt(0, K_RDV, 32'h0, "reset_rdata_valid");
        applyStimulus(1);
        rst = 1'b0;
        expectAt(0, K_COPRST, 32'h0, "post_reset_cop_rst");
        expectAt(0, K_STATUS, 32'h0, "post_reset_status");
        applyStimulus(1);

        // Host writes then read of word 2
        for (int a = 0; a < 4; a++) begin
            setCmd(CMD_WRITE, 0);
            bus.address_register = a;
            bus.data_in_register = 32'h11 * (a + 1);
            wr_q.push_back({10'(a), 32'h11 * (a + 1)});
            applyStimulus(1);
        end
        setCmd(CMD_READ, 0);
        bus.address_register = 32'd2;
        expectAt(0, K_RVALID, 32'h1, "host_read_valid");
        expectAt(0, K_RADDR, 32'h0, "host_read_addr");
        expectAt(1, K_DATAO, 32'h33, "host_read_data");
        applyStimulus(2);

        // Start ch0 with delayed ready, then done+accept after 10 running cycles
        setCmd(CMD_START, 0);
        for (int k = 0; k < 3; k++) begin
            expectAt(0, K_STARTV, 32'h1, "start_valid_waiting");
            expectAt(0, K_STATUS, 32'h0, "status_before_ready");
            applyStimulus(1);
        end
        bus.cop_start_ready = 2'b01;
        expectAt(0, K_STARTV, 32'h1, "start_valid_handshake");
        expectAt(1, K_STATUS, 32'h8000_0001, "ch0_running");
        applyStimulus(1);
        bus.cop_start_ready = 2'b00;
        expectAt(0, K_STARTV, 32'h0, "start_held_no_effect");
        applyStimulus(1);
        setCmd(CMD_NOP, 0);
        applyStimulus(8);
        bus.cop_done   = 2'b01;
        bus.cop_accept = 2'b01;
        expectAt(1, K_STATUS, 32'h2, "ch0_accepted");
        applyStimulus(1);
        bus.cop_done   = 2'b00;
        bus.cop_accept = 2'b00;
        setCmd(CMD_READ_ELAPSED, 0);
        expectAt(0, K_DATAO, 32'd10, "ch0_elapsed_10");
        applyStimulus(1);

        // Both channels running: alternating grants
        setCmd(CMD_RESTART, 0);
        expectAt(1, K_STATUS, 32'h0, "ch0_restart_idle");
        applyStimulus(1);
        setCmd(CMD_START, 0);
        bus.cop_start_ready = 2'b01;
        applyStimulus(1);
        setCmd(CMD_START, 1);
        bus.cop_start_ready = 2'b10;
        applyStimulus(1);
        setCmd(CMD_NOP, 0);
        bus.cop_start_ready = 2'b00;
        bus.cop_mem_valid   = 2'b11;
        bus.cop_mem_addr    = {8'hB1, 8'hA0};
        expectAt(0, K_STATUS, 32'h8000_0011, "both_running");
        for (int k = 0; k < 4; k++) begin
            gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            expectAt(0, K_READY, {30'd0, gnt}, "rr_grant");
            expectAt(0, K_RADDR, (k % 2 == 0) ? 32'hA0 : 32'hB1, "rr_mem_addr");
            expectAt(1, K_RDV, {30'd0, gnt}, "rdata_valid_delay");
            rd_q.push_back(gnt);
            applyStimulus(1);
        end
        bus.cop_mem_valid = 2'b00;

        // Host access while busy is ignored
        setCmd(CMD_WRITE, 0);
        bus.address_register = 32'd7;
        bus.data_in_register = 32'h99;
        expectAt(0, K_WVALID, 32'h0, "write_while_busy");
        applyStimulus(1);
        setCmd(CMD_READ, 0);
        expectAt(0, K_RVALID, 32'h0, "read_while_busy");
        expectAt(0, K_DATAO, 32'h0, "read_data_while_busy");
        applyStimulus(1);

        // Abort both channels, then a write goes through
        setCmd(CMD_ABORT, 0);
        expectAt(0, K_COPRST, 32'h1, "abort_ch0_cop_rst");
        expectAt(1, K_STATUS, 32'h8000_0010, "abort_ch0_idle");
        applyStimulus(1);
        setCmd(CMD_ABORT, 1);
        expectAt(0, K_COPRST, 32'h2, "abort_ch1_cop_rst");
        expectAt(1, K_STATUS, 32'h0, "abort_ch1_idle");
        applyStimulus(1);
        setCmd(CMD_WRITE, 0);
        bus.address_register = 32'd5;
        bus.data_in_register = 32'h55;
        wr_q.push_back({10'd5, 32'h55});
        expectAt(0, K_WVALID, 32'h1, "write_after_abort");
        applyStimulus(1);

        // Timeout of 5 cycles on ch1
        bus.timeout_register = 32'd5;
        setCmd(CMD_START, 1);
        bus.cop_start_ready = 2'b10;
        expectAt(0, K_STARTV, 32'h2, "ch1_start_valid");
        applyStimulus(1);
        setCmd(CMD_NOP, 0);
        bus.cop_start_ready = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            expectAt(0, K_COPRST, (k == 5) ? 32'h2 : 32'h0, "timeout_cop_rst");
            expectAt(0, K_STATUS, 32'h8000_0010, "ch1_running_pre_timeout");
            applyStimulus(1);
        end
        setCmd(CMD_READ_ELAPSED, 1);
        expectAt(0, K_STATUS, 32'h50, "ch1_timeout");
        expectAt(0, K_COPRST, 32'h0, "timeout_pulse_ends");
        expectAt(0, K_DATAO, 32'd5, "ch1_elapsed_5");
        applyStimulus(1);
        setCmd(CMD_RESTART, 1);
        expectAt(1, K_STATUS, 32'h0, "ch1_restart_idle");
        applyStimulus(1);
        bus.timeout_register = 32'd0;

        // Error wins over done
        setCmd(CMD_START, 0);
        bus.cop_start_ready = 2'b01;
        applyStimulus(1);
        setCmd(CMD_NOP, 0);
        bus.cop_start_ready = 2'b00;
        bus.cop_error  = 2'b01;
        bus.cop_done   = 2'b01;
        bus.cop_accept = 2'b01;
        expectAt(1, K_STATUS, 32'h4, "error_over_done");
        applyStimulus(1);
        bus.cop_error  = 2'b00;
        bus.cop_done   = 2'b00;
        bus.cop_accept = 2'b00;
        setCmd(CMD_RESTART, 0);
        applyStimulus(1);

        // Simultaneous done on both channels, one accept and one reject
        setCmd(CMD_START, 0);
        bus.cop_start_ready = 2'b01;
        applyStimulus(1);
        setCmd(CMD_START, 1);
        bus.cop_start_ready = 2'b10;
        applyStimulus(1);
        setCmd(CMD_NOP, 0);
        bus.cop_start_ready = 2'b00;
        bus.cop_done   = 2'b11;
        bus.cop_accept = 2'b01;
        expectAt(1, K_STATUS, 32'h32, "dual_done");
        applyStimulus(1);
        bus.cop_done   = 2'b00;
        bus.cop_accept = 2'b00;
        setCmd(CMD_RESTART, 0);
        applyStimulus(1);
        setCmd(CMD_RESTART, 1);
        expectAt(1, K_STATUS, 32'h0, "dual_restart_idle");
        applyStimulus(1);

        // Invalid channel commands are no-ops
        setCmd(CMD_START, 2);
        expectAt(0, K_STARTV, 32'h0, "invalid_ch_start");
        expectAt(1, K_STATUS, 32'h0, "invalid_ch_status");
        applyStimulus(1);
        setCmd(CMD_READ_ELAPSED, 5);
        expectAt(0, K_DATAO, 32'h0, "invalid_ch_data_o");
        applyStimulus(1);

        // CMD_RESET mid-run drops in-flight read data and clears counters
        setCmd(CMD_START, 0);
        bus.cop_start_ready = 2'b01;
        applyStimulus(1);
        setCmd(CMD_START, 1);
        bus.cop_start_ready = 2'b10;
        applyStimulus(1);
        setCmd(CMD_NOP, 0);
        bus.cop_start_ready = 2'b00;
        bus.cop_mem_valid   = 2'b01;
        expectAt(0, K_READY, 32'h1, "grant_before_reset");
        applyStimulus(1);
        bus.cop_mem_valid = 2'b00;
        setCmd(CMD_RESET, 0);
        expectAt(0, K_COPRST, 32'h3, "cmd_reset_cop_rst");
        expectAt(0, K_RDV, 32'h0, "cmd_reset_drops_rdata");
        expectAt(0, K_STATUS, 32'h8000_0011, "running_before_cmd_reset");
        applyStimulus(1);
        setCmd(CMD_READ_ELAPSED, 0);
        expectAt(0, K_STATUS, 32'h0, "cmd_reset_status");
        expectAt(0, K_COPRST, 32'h0, "cmd_reset_released");
        expectAt(0, K_DATAO, 32'h0, "cmd_reset_elapsed");
        applyStimulus(1);
        setCmd(CMD_NOP, 0);
        applyStimulus(3);

        checkOutput("pending_checks_left", 64'(pend.size()), 64'd0);
        checkOutput("writes_left", 64'(wr_q.size()), 64'd0);
        checkOutput("rdata_events_left", 64'(rd_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
